// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a
// built-in clear sequence that zeroes every register from address 0 upward.
module regfile_wr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned AW   = 3,
   parameter int unsigned DW   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_data,
   input  logic                 clear_start,
   output logic [NREQ-1:0]      gnt,
   output logic                 wr_en,
   output logic [AW-1:0]        wr_addr,
   output logic [DW-1:0]        wr_data,
   output logic                 busy
);

   localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned NREG = 1 << AW;

   typedef enum logic {
      ARB   = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              wr_en_q, wr_en_d;
   logic [AW-1:0]     wr_addr_q, wr_addr_d;
   logic [DW-1:0]     wr_data_q, wr_data_d;
   logic              busy_q, busy_d;

   logic [NREQ-1:0]   eligible;
   logic              found;
   logic [PW-1:0]     win_idx;

   // Round-robin search from ptr; the current grant holder is masked out.
   always_comb begin
      eligible = req & ~gnt_q;
      found    = 1'b0;
      win_idx  = '0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         int unsigned cand;
         cand = (32'(ptr_q) + off) % NREQ;
         if (!found && eligible[cand[PW-1:0]]) begin
            found   = 1'b1;
            win_idx = PW'(cand);
         end
      end
   end

   // Next-state and next-output logic; wr_addr/wr_data hold unless a write is issued.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      clr_cnt_d = clr_cnt_q;
      gnt_d     = '0;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      busy_d    = busy_q;
      case (state_q)
         ARB: begin
            if (clear_start) begin
               // First clear write (address 0) lands in the first CLEAR cycle.
               state_d   = CLEAR;
               clr_cnt_d = '0;
               busy_d    = 1'b1;
               wr_en_d   = 1'b1;
               wr_addr_d = '0;
               wr_data_d = '0;
            end else if (found) begin
               gnt_d     = NREQ'(1) << win_idx;
               wr_en_d   = 1'b1;
               wr_addr_d = req_addr[win_idx*AW +: AW];
               wr_data_d = req_data[win_idx*DW +: DW];
               ptr_d     = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
            end
         end
         CLEAR: begin
            if (clr_cnt_q == AW'(NREG - 1)) begin
               state_d   = ARB;
               busy_d    = 1'b0;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + AW'(1);
               wr_en_d   = 1'b1;
               wr_addr_d = clr_cnt_q + AW'(1);
               wr_data_d = '0;
            end
         end
         default: begin
            state_d = ARB;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any in-flight write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ARB;
         ptr_q     <= '0;
         clr_cnt_q <= '0;
         gnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         clr_cnt_q <= clr_cnt_d;
         gnt_q     <= gnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
      end
   end

   assign gnt     = gnt_q;
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed table, clear/reset corner cases,
// and randomized traffic against a behavioural model.
module tb_regfile_wr_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned AW   = 3;
   localparam int unsigned DW   = 32;
   localparam int unsigned NREG = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*DW-1:0]   req_data;
   logic                 clear_start;
   logic [NREQ-1:0]      gnt;
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic [DW-1:0]        wr_data;
   logic                 busy;

   int passed = 0;
   int total  = 0;

   regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
      .clear_start(clear_start), .gnt(gnt), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NREQ-1:0] req;
      logic [NREQ-1:0] gnt;
      logic            en;
      logic [AW-1:0]   addr;
      logic [DW-1:0]   data;
      logic            busy;
   } vec_t;

   vec_t tbl [15];

   // behavioural model state
   bit              m_clear;
   int              m_idx;
   int              m_ptr;
   int              m_gnt;
   logic            m_en;
   logic [AW-1:0]   m_wa;
   logic [DW-1:0]   m_wd;
   logic            m_busy;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else
         passed++;
   endtask

   task automatic check_out(input string name, input logic [NREQ-1:0] eg, input logic een,
                            input logic [AW-1:0] ea, input logic [DW-1:0] ed, input logic eb);
      chk({name, ".gnt"},     64'(gnt),     64'(eg));
      chk({name, ".wr_en"},   64'(wr_en),   64'(een));
      chk({name, ".wr_addr"}, 64'(wr_addr), 64'(ea));
      chk({name, ".wr_data"}, 64'(wr_data), 64'(ed));
      chk({name, ".busy"},    64'(busy),    64'(eb));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_clear = 1'b0; m_idx = 0; m_ptr = 0; m_gnt = -1;
      m_en = 1'b0; m_wa = '0; m_wd = '0; m_busy = 1'b0;
   endtask

   // One clock edge of the arbiter, from the rules: clear walks 0..NREG-1,
   // otherwise the first requester at or after ptr (not just granted) wins.
   task automatic model_step();
      int win;
      if (m_clear) begin
         m_gnt = -1;
         if (m_idx == NREG - 1) begin
            m_clear = 1'b0; m_busy = 1'b0; m_en = 1'b0;
         end else begin
            m_idx = m_idx + 1;
            m_en = 1'b1; m_wa = AW'(m_idx); m_wd = '0;
         end
      end else if (clear_start) begin
         m_clear = 1'b1; m_idx = 0; m_busy = 1'b1; m_en = 1'b1;
         m_wa = '0; m_wd = '0; m_gnt = -1;
      end else begin
         win = -1;
         for (int off = 0; off < NREQ; off++) begin
            int k;
            k = (m_ptr + off) % NREQ;
            if (win < 0 && req[k] && k != m_gnt) win = k;
         end
         if (win >= 0) begin
            m_gnt = win; m_en = 1'b1;
            m_wa = req_addr[win*AW +: AW];
            m_wd = req_data[win*DW +: DW];
            m_ptr = (win + 1) % NREQ;
         end else begin
            m_gnt = -1; m_en = 1'b0;
         end
      end
   endtask

   function automatic logic [NREQ-1:0] m_gnt_vec();
      return (m_gnt < 0) ? '0 : NREQ'(1) << m_gnt;
   endfunction

   initial begin
      // requester i: addr (i+3)%8, data A5A5A5A5 ^ ((i^2)*01010101)
      rst = 1'b1; req = '0; clear_start = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         req_addr[i*AW +: AW] = AW'((i + 3) % 8);
         req_data[i*DW +: DW] = 32'hA5A5A5A5 ^ (32'(i ^ 2) * 32'h01010101);
      end

      tbl[0]  = '{4'b1111, 4'b0001, 1'b1, 3'd3, 32'hA7A7A7A7, 1'b0};
      tbl[1]  = '{4'b1111, 4'b0010, 1'b1, 3'd4, 32'hA6A6A6A6, 1'b0};
      tbl[2]  = '{4'b1111, 4'b0100, 1'b1, 3'd5, 32'hA5A5A5A5, 1'b0};
      tbl[3]  = '{4'b1111, 4'b1000, 1'b1, 3'd6, 32'hA4A4A4A4, 1'b0};
      tbl[4]  = '{4'b1111, 4'b0001, 1'b1, 3'd3, 32'hA7A7A7A7, 1'b0};
      tbl[5]  = '{4'b0000, 4'b0000, 1'b0, 3'd3, 32'hA7A7A7A7, 1'b0};
      tbl[6]  = '{4'b0100, 4'b0100, 1'b1, 3'd5, 32'hA5A5A5A5, 1'b0};
      tbl[7]  = '{4'b0000, 4'b0000, 1'b0, 3'd5, 32'hA5A5A5A5, 1'b0};
      tbl[8]  = '{4'b0010, 4'b0010, 1'b1, 3'd4, 32'hA6A6A6A6, 1'b0};
      tbl[9]  = '{4'b0010, 4'b0000, 1'b0, 3'd4, 32'hA6A6A6A6, 1'b0};
      tbl[10] = '{4'b0010, 4'b0010, 1'b1, 3'd4, 32'hA6A6A6A6, 1'b0};
      tbl[11] = '{4'b0010, 4'b0000, 1'b0, 3'd4, 32'hA6A6A6A6, 1'b0};
      tbl[12] = '{4'b0000, 4'b0000, 1'b0, 3'd4, 32'hA6A6A6A6, 1'b0};
      tbl[13] = '{4'b1001, 4'b1000, 1'b1, 3'd6, 32'hA4A4A4A4, 1'b0};
      tbl[14] = '{4'b1001, 4'b0001, 1'b1, 3'd3, 32'hA7A7A7A7, 1'b0};

      #2;
      check_out("reset", '0, 1'b0, '0, '0, 1'b0);
      @(negedge clk) rst = 1'b0;

      for (int r = 0; r < 15; r++) begin
         @(negedge clk) req = tbl[r].req;
         step();
         check_out($sformatf("tbl%0d", r), tbl[r].gnt, tbl[r].en, tbl[r].addr, tbl[r].data, tbl[r].busy);
      end

      // clear wins over a same-cycle request, which is served after CLEAR
      @(negedge clk) begin req = 4'b0001; clear_start = 1'b1; end
      step();
      check_out("clr_entry", '0, 1'b1, 3'd0, '0, 1'b1);
      @(negedge clk) clear_start = 1'b0;
      for (int c = 1; c < NREG; c++) begin
         step();
         check_out($sformatf("clr_walk%0d", c), '0, 1'b1, AW'(c), '0, 1'b1);
      end
      step();
      check_out("clr_exit", '0, 1'b0, 3'd7, '0, 1'b0);
      step();
      check_out("post_clr_gnt", 4'b0001, 1'b1, 3'd3, 32'hA7A7A7A7, 1'b0);
      @(negedge clk) req = '0;
      step();
      check_out("post_clr_idle", '0, 1'b0, 3'd3, 32'hA7A7A7A7, 1'b0);

      // clear_start repeated mid-CLEAR must not restart or extend it
      @(negedge clk) clear_start = 1'b1;
      step();
      check_out("rst_clr_entry", '0, 1'b1, 3'd0, '0, 1'b1);
      for (int c = 1; c < NREG; c++) begin
         @(negedge clk) clear_start = (c == 3);
         step();
         check_out($sformatf("reclr_walk%0d", c), '0, 1'b1, AW'(c), '0, 1'b1);
      end
      @(negedge clk) clear_start = 1'b0;
      step();
      check_out("reclr_exit", '0, 1'b0, 3'd7, '0, 1'b0);
      step();
      check_out("reclr_no_ext", '0, 1'b0, 3'd7, '0, 1'b0);

      // asynchronous reset in the middle of CLEAR
      @(negedge clk) clear_start = 1'b1;
      step();
      @(negedge clk) clear_start = 1'b0;
      for (int c = 1; c <= 4; c++) step();
      check_out("pre_rst_clr4", '0, 1'b1, 3'd4, '0, 1'b1);
      #1 rst = 1'b1;
      #1;
      check_out("async_rst", '0, 1'b0, '0, '0, 1'b0);
      @(negedge clk) begin rst = 1'b0; req = 4'b1000; end
      step();
      check_out("after_rst_gnt3", 4'b1000, 1'b1, 3'd6, 32'hA4A4A4A4, 1'b0);
      @(negedge clk) req = '0;
      step();
      check_out("after_rst_idle", '0, 1'b0, 3'd6, 32'hA4A4A4A4, 1'b0);

      // randomized traffic against the model
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk) begin
            req         = NREQ'($urandom);
            clear_start = ($urandom_range(0, 39) == 0);
            req_addr    = (NREQ*AW)'($urandom);
            req_data    = {$urandom, $urandom, $urandom, $urandom};
         end
         @(posedge clk);
         model_step();
         #1;
         check_out("rand", m_gnt_vec(), m_en, m_wa, m_wd, m_busy);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
